// File: rtl/dtcm_arbiter_if.sv
// Bus bundle between the DTCM arbiter, its three requesters (data, fetch, DMA)
// and the single-port SRAM macro. slave = arbiter side, master = requester/SRAM side.
interface dtcm_arbiter_if #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int WORD_AW = 13
);
  logic               data_req;
  logic               data_rd0_wr1;
  logic [AW-1:0]      data_addr;
  logic [DW-1:0]      data_wdata;
  logic [3:0]         data_be;
  logic               data_gnt;
  logic [DW-1:0]      data_rdata;
  logic               data_rvalid;

  logic               instr_req;
  logic [AW-1:0]      instr_addr;
  logic               instr_gnt;
  logic [DW-1:0]      instr_rdata;
  logic               instr_rvalid;

  logic               dma_req;
  logic               dma_rd0_wr1;
  logic               dma_lock;
  logic [AW-1:0]      dma_addr;
  logic [DW-1:0]      dma_wdata;
  logic               dma_gnt;
  logic [DW-1:0]      dma_rdata;
  logic               dma_rvalid;

  logic               mem_cs;
  logic               mem_we;
  logic [WORD_AW-1:0] mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [3:0]         mem_be;
  logic [DW-1:0]      mem_rdata;

  modport slave (
    input  data_req, data_rd0_wr1, data_addr, data_wdata, data_be,
    output data_gnt, data_rdata, data_rvalid,
    input  instr_req, instr_addr,
    output instr_gnt, instr_rdata, instr_rvalid,
    input  dma_req, dma_rd0_wr1, dma_lock, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_cs, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

  modport master (
    output data_req, data_rd0_wr1, data_addr, data_wdata, data_be,
    input  data_gnt, data_rdata, data_rvalid,
    output instr_req, instr_addr,
    input  instr_gnt, instr_rdata, instr_rvalid,
    output dma_req, dma_rd0_wr1, dma_lock, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_cs, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );
endinterface

// File: rtl/dtcm_arbiter.sv
// Single-port DTCM arbiter: data / fetch / DMA with starvation promotion and DMA burst lock.
// Define DTCM_ARB_RR_EN for round-robin base priority instead of fixed dma > data > instr.
module dtcm_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int WORD_AW      = 13,
  parameter int STARVE_LIMIT = 8,
  parameter int LOCK_MAX     = 16
) (
  input logic             clk,
  input logic             rstn,
  dtcm_arbiter_if.slave   bus
);
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam int LCW = $clog2(LOCK_MAX + 1);
  localparam int R_DATA  = 0;
  localparam int R_INSTR = 1;
  localparam int R_DMA   = 2;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_DATA, OWN_INSTR, OWN_DMA} owner_e;

  lock_state_e    state_q;
  logic [LCW-1:0] lock_cnt_q;
  logic           holdoff_q;
  owner_e         owner_q, owner_d;

  logic [2:0] req, eligible, starved, gnt;
  logic [1:0] rank_start;
  logic       lock_hold;

  assign req       = {bus.dma_req, bus.instr_req, bus.data_req};
  // The cycle dma_lock drops is arbitrated normally even though state_q is still LOCKED.
  assign lock_hold = (state_q == LOCKED) && bus.dma_lock;
  assign eligible  = {req[R_DMA] && !holdoff_q,
                      req[R_INSTR] && !lock_hold,
                      req[R_DATA] && !lock_hold};

  for (genvar gi = 0; gi < 3; gi++) begin : g_starve
    logic [SCW-1:0] cnt_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt_q <= '0;
      end else if (!req[gi] || gnt[gi]) begin
        cnt_q <= '0;
      end else if (cnt_q < SCW'(STARVE_LIMIT)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign starved[gi] = eligible[gi] && (cnt_q >= SCW'(STARVE_LIMIT));
  end

  // First set bit of m scanning upward from index start, wrapping after 2.
  function automatic logic [2:0] pick(input logic [2:0] m, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    idx = start;
    for (int k = 0; k < 3; k++) begin
      if (m[idx] && (res == 3'b000)) res[idx] = 1'b1;
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
    return res;
  endfunction

`ifdef DTCM_ARB_RR_EN
  logic [1:0] last_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= 2'(R_DMA);
    end else if ((|gnt) && (state_q != LOCKED)) begin
      last_q <= gnt[R_DATA] ? 2'(R_DATA) : (gnt[R_INSTR] ? 2'(R_INSTR) : 2'(R_DMA));
    end
  end
  assign rank_start = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
`else
  // Scan order dma, data, instr gives the fixed priority.
  assign rank_start = 2'(R_DMA);
`endif

  always_comb begin
    gnt = (|starved) ? pick(starved, rank_start) : pick(eligible, rank_start);
  end

  always_comb begin
    bus.mem_cs    = |gnt;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = 4'h0;
    owner_d       = OWN_NONE;
    if (gnt[R_DMA]) begin
      bus.mem_we    = bus.dma_rd0_wr1;
      bus.mem_addr  = bus.dma_addr[WORD_AW+1:2];
      bus.mem_wdata = bus.dma_wdata;
      bus.mem_be    = 4'hF;
      owner_d       = bus.dma_rd0_wr1 ? OWN_NONE : OWN_DMA;
    end else if (gnt[R_DATA]) begin
      bus.mem_we    = bus.data_rd0_wr1;
      bus.mem_addr  = bus.data_addr[WORD_AW+1:2];
      bus.mem_wdata = bus.data_wdata;
      bus.mem_be    = bus.data_be;
      owner_d       = bus.data_rd0_wr1 ? OWN_NONE : OWN_DATA;
    end else if (gnt[R_INSTR]) begin
      bus.mem_addr  = bus.instr_addr[WORD_AW+1:2];
      owner_d       = OWN_INSTR;
    end
  end

  // Lock FSM; the entering grant counts toward LOCK_MAX, and a forced release
  // excludes DMA for exactly one cycle via holdoff_q.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= UNLOCKED;
      lock_cnt_q <= '0;
      holdoff_q  <= 1'b0;
      owner_q    <= OWN_NONE;
    end else begin
      holdoff_q <= 1'b0;
      owner_q   <= owner_d;
      case (state_q)
        UNLOCKED: begin
          if (gnt[R_DMA] && bus.dma_lock) begin
            if (LOCK_MAX <= 1) begin
              holdoff_q <= 1'b1;
            end else begin
              state_q    <= LOCKED;
              lock_cnt_q <= LCW'(1);
            end
          end
        end
        LOCKED: begin
          if (!bus.dma_lock) begin
            state_q    <= UNLOCKED;
            lock_cnt_q <= '0;
          end else if (gnt[R_DMA]) begin
            if (lock_cnt_q == LCW'(LOCK_MAX - 1)) begin
              state_q    <= UNLOCKED;
              lock_cnt_q <= '0;
              holdoff_q  <= 1'b1;
            end else begin
              lock_cnt_q <= lock_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.data_gnt     = gnt[R_DATA];
  assign bus.instr_gnt    = gnt[R_INSTR];
  assign bus.dma_gnt      = gnt[R_DMA];
  assign bus.data_rvalid  = (owner_q == OWN_DATA);
  assign bus.instr_rvalid = (owner_q == OWN_INSTR);
  assign bus.dma_rvalid   = (owner_q == OWN_DMA);
  assign bus.data_rdata   = bus.mem_rdata;
  assign bus.instr_rdata  = bus.mem_rdata;
  assign bus.dma_rdata    = bus.mem_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.data_addr[AW-1:WORD_AW+2], bus.data_addr[1:0],
                              bus.instr_addr[AW-1:WORD_AW+2], bus.instr_addr[1:0],
                              bus.dma_addr[AW-1:WORD_AW+2], bus.dma_addr[1:0]};
endmodule

// File: tb/tb_dtcm_arbiter.sv
// Self-checking bench for dtcm_arbiter: table vectors, directed corner sequences and
// randomized traffic against a rule-level model with a shadow memory.
module tb_dtcm_arbiter;
  localparam int AW = 32, DW = 32, WORD_AW = 13, STARVE_LIMIT = 8, LOCK_MAX = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dtcm_arbiter_if #(.AW(AW), .DW(DW), .WORD_AW(WORD_AW)) bus();
  dtcm_arbiter #(.AW(AW), .DW(DW), .WORD_AW(WORD_AW), .STARVE_LIMIT(STARVE_LIMIT),
                 .LOCK_MAX(LOCK_MAX)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  // SRAM macro model with registered read
  logic [31:0] sram   [0:8191];
  logic [31:0] shadow [0:8191];
  logic [31:0] sram_rdata = 32'h0;
  always @(posedge clk) begin
    if (bus.mem_cs) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) sram[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram[bus.mem_addr];
      end
    end
  end
  assign bus.mem_rdata = sram_rdata;

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester state (index 0 = data, 1 = instr, 2 = dma)
  logic [2:0]  rq = '0, rq_we = '0, persist = '0;
  logic [31:0] rq_addr [3], rq_wdata [3];
  logic [3:0]  rq_be [3];
  logic        lock_v = 1'b0;
  bit          verbose = 1'b1;

  task automatic drive();
    bus.data_req = rq[0]; bus.data_rd0_wr1 = rq_we[0]; bus.data_addr = rq_addr[0];
    bus.data_wdata = rq_wdata[0]; bus.data_be = rq_be[0];
    bus.instr_req = rq[1]; bus.instr_addr = rq_addr[1];
    bus.dma_req = rq[2]; bus.dma_rd0_wr1 = rq_we[2]; bus.dma_addr = rq_addr[2];
    bus.dma_wdata = rq_wdata[2]; bus.dma_lock = lock_v;
  endtask

  task automatic set_req(input int i, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    rq[i] = 1'b1; rq_we[i] = (i == 1) ? 1'b0 : we; rq_addr[i] = a; rq_wdata[i] = wd;
    rq_be[i] = be;
  endtask

  // Reference model: rule-level state
  int m_starve [3];
  bit m_locked, m_holdoff;
  int m_lock_n, m_last, m_owner;
  logic [31:0] m_rdata;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_starve[i] = 0;
    m_locked = 0; m_holdoff = 0; m_lock_n = 0; m_last = 2; m_owner = -1; m_rdata = '0;
  endtask

  function automatic int model_grant();
    int order [3];
    bit cand [3];
`ifdef DTCM_ARB_RR_EN
    for (int k = 0; k < 3; k++) order[k] = (m_last + 1 + k) % 3;
`else
    order[0] = 2; order[1] = 0; order[2] = 1;
`endif
    for (int i = 0; i < 3; i++)
      cand[i] = rq[i] && !(m_locked && lock_v && i != 2) && !(m_holdoff && i == 2);
    for (int k = 0; k < 3; k++)
      if (cand[order[k]] && m_starve[order[k]] >= STARVE_LIMIT) return order[k];
    for (int k = 0; k < 3; k++)
      if (cand[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic model_update(input int g);
    bit was_locked;
    logic [12:0] w;
    was_locked = m_locked;
    for (int i = 0; i < 3; i++)
      m_starve[i] = (!rq[i] || g == i) ? 0 :
                    ((m_starve[i] < STARVE_LIMIT) ? m_starve[i] + 1 : m_starve[i]);
    m_holdoff = 0;
    if (m_locked && !lock_v) begin
      m_locked = 0; m_lock_n = 0;
    end else if (g == 2 && lock_v) begin
      m_lock_n++; m_locked = 1;
      if (m_lock_n == LOCK_MAX) begin m_locked = 0; m_lock_n = 0; m_holdoff = 1; end
    end
`ifdef DTCM_ARB_RR_EN
    if (g >= 0 && !was_locked) m_last = g;
`else
    if (was_locked) m_last = 2;
`endif
    m_owner = -1;
    if (g >= 0) begin
      w = rq_addr[g][14:2];
      if (rq_we[g]) begin
        for (int b = 0; b < 4; b++)
          if (g == 2 || rq_be[g][b]) shadow[w][8*b +: 8] = rq_wdata[g][8*b +: 8];
      end else begin
        m_owner = g; m_rdata = shadow[w];
      end
    end
  endtask

  // Sampled DUT values of the most recent step
  logic [2:0] a_gnt, a_rvalid;
  logic a_we;
  logic [12:0] a_addr;
  logic [3:0] a_be;
  logic [31:0] a_wdata;

  task automatic step();
    int g;
    logic [2:0] e_gnt, e_rv;
    logic [31:0] rd;
    @(negedge clk);
    g = model_grant();
    e_gnt = (g < 0) ? 3'b000 : (3'b001 << g);
    e_rv  = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
    a_gnt = {bus.dma_gnt, bus.instr_gnt, bus.data_gnt};
    a_rvalid = {bus.dma_rvalid, bus.instr_rvalid, bus.data_rvalid};
    a_we = bus.mem_we; a_addr = bus.mem_addr; a_be = bus.mem_be; a_wdata = bus.mem_wdata;
    chk("gnt", 32'(a_gnt), 32'(e_gnt));
    chk("mem_cs", 32'(bus.mem_cs), 32'(g >= 0));
    chk("mem_we", 32'(a_we), (g >= 0) ? 32'(rq_we[g]) : 32'd0);
    chk("mem_addr", 32'(a_addr), (g >= 0) ? 32'(rq_addr[g][14:2]) : 32'd0);
    chk("mem_be", 32'(a_be), (g == 0) ? 32'(rq_be[0]) : ((g == 2) ? 32'hF : 32'h0));
    chk("mem_wdata", a_wdata, (g == 0 || g == 2) ? rq_wdata[g] : 32'h0);
    chk("rvalid", 32'(a_rvalid), 32'(e_rv));
    if (m_owner >= 0) begin
      rd = (m_owner == 0) ? bus.data_rdata : ((m_owner == 1) ? bus.instr_rdata : bus.dma_rdata);
      chk("rdata", rd, m_rdata);
    end
    if (verbose)
      $display("txn t=%0t req=%b lock=%b gnt=%b we=%b addr=%h be=%h wdata=%h rvalid=%b",
               $time, rq, lock_v, a_gnt, a_we, a_addr, a_be, a_wdata, a_rvalid);
    model_update(g);
    if (g >= 0 && !persist[g]) rq[g] = 1'b0;
    @(posedge clk); #1;
    drive();
  endtask

  task automatic do_reset();
    rstn = 1'b0; rq = '0; lock_v = 1'b0; persist = '0; drive(); model_reset();
    @(negedge clk);
    chk("rst_gnt", 32'({bus.dma_gnt, bus.instr_gnt, bus.data_gnt}), 32'd0);
    chk("rst_rvalid", 32'({bus.dma_rvalid, bus.instr_rvalid, bus.data_rvalid}), 32'd0);
    chk("rst_mem_cs", 32'(bus.mem_cs), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic        d_we;   logic [31:0] d_addr;  logic [31:0] d_wdata; logic [3:0] d_be;
    logic [31:0] i_addr;
    logic        dm_we;  logic [31:0] dm_addr; logic [31:0] dm_wdata;
    logic [2:0]  e_gnt;  logic e_we; logic [12:0] e_addr; logic [3:0] e_be; logic [31:0] e_wdata;
  } vec_t;
  vec_t vecs [8];

  logic [2:0] seq [20];
  int first_data, n_dma;

  initial begin
    vecs[0] = '{3'b001, 1'b0, 32'h10, 32'h1111_2222, 4'hF, 32'h0, 1'b0, 32'h0, 32'h0,
                3'b001, 1'b0, 13'h4, 4'hF, 32'h1111_2222};
    vecs[1] = '{3'b101, 1'b1, 32'h20, 32'hA5A5_0000, 4'hC, 32'h0, 1'b1, 32'h40, 32'hDEAD_BEEF,
                3'b100, 1'b1, 13'h10, 4'hF, 32'hDEAD_BEEF};
    vecs[2] = '{3'b010, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1004, 1'b0, 32'h0, 32'h0,
                3'b010, 1'b0, 13'h401, 4'h0, 32'h0};
    vecs[3] = '{3'b011, 1'b0, 32'h8, 32'h3, 4'h1, 32'h2000, 1'b0, 32'h0, 32'h0,
                3'b001, 1'b0, 13'h2, 4'h1, 32'h3};
    vecs[4] = '{3'b111, 1'b0, 32'h8, 32'h0, 4'hF, 32'h2000, 1'b0, 32'hFFFF_8007, 32'h55,
                3'b100, 1'b0, 13'h1, 4'hF, 32'h55};
    vecs[5] = '{3'b001, 1'b1, 32'h7FFF, 32'h1234_5678, 4'h3, 32'h0, 1'b0, 32'h0, 32'h0,
                3'b001, 1'b1, 13'h1FFF, 4'h3, 32'h1234_5678};
    vecs[6] = '{3'b100, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hC, 32'hCAFE_F00D,
                3'b100, 1'b1, 13'h3, 4'hF, 32'hCAFE_F00D};
    vecs[7] = '{3'b000, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0,
                3'b000, 1'b0, 13'h0, 4'h0, 32'h0};

    for (int i = 0; i < 8192; i++) begin
      sram[i] = $urandom; shadow[i] = sram[i];
    end
    for (int i = 0; i < 3; i++) begin rq_addr[i] = '0; rq_wdata[i] = '0; rq_be[i] = '0; end
    do_reset();

`ifndef DTCM_ARB_RR_EN
    // Table-driven single-cycle vectors, each followed by an idle cycle
    for (int v = 0; v < 8; v++) begin
      rq = '0;
      if (vecs[v].req[0]) set_req(0, vecs[v].d_we, vecs[v].d_addr, vecs[v].d_wdata, vecs[v].d_be);
      if (vecs[v].req[1]) set_req(1, 1'b0, vecs[v].i_addr, 32'h0, 4'h0);
      if (vecs[v].req[2]) set_req(2, vecs[v].dm_we, vecs[v].dm_addr, vecs[v].dm_wdata, 4'hF);
      drive(); step();
      chk($sformatf("vec%0d_gnt", v), 32'(a_gnt), 32'(vecs[v].e_gnt));
      chk($sformatf("vec%0d_we", v), 32'(a_we), 32'(vecs[v].e_we));
      chk($sformatf("vec%0d_addr", v), 32'(a_addr), 32'(vecs[v].e_addr));
      chk($sformatf("vec%0d_be", v), 32'(a_be), 32'(vecs[v].e_be));
      chk($sformatf("vec%0d_wdata", v), a_wdata, vecs[v].e_wdata);
      rq = '0; drive(); step();
      if (v == 0) chk("tp1_data_rvalid", 32'(a_rvalid), 32'b001);
    end

    // Data write and DMA write together: DMA first, data next cycle
    set_req(0, 1'b1, 32'h20, 32'hA5A5_0000, 4'b1100);
    set_req(2, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hF);
    drive(); step();
    chk("tp2_dma_first", 32'(a_gnt), 32'b100);
    chk("tp2_dma_be", 32'(a_be), 32'hF);
    step();
    chk("tp2_data_second", 32'(a_gnt), 32'b001);
    chk("tp2_data_addr", 32'(a_addr), 32'h8);
    chk("tp2_data_be", 32'(a_be), 32'hC);
    rq = '0; drive(); step();

    // Starvation: DMA and data both continuous, no lock
    persist = 3'b101; first_data = -1;
    set_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
    set_req(2, 1'b0, 32'h200, 32'h0, 4'hF);
    drive();
    for (int c = 0; c < 12; c++) begin
      step();
      seq[c] = a_gnt;
      if (a_gnt[0] && first_data < 0) first_data = c;
    end
    chk("starve_data_cycle", 32'(first_data), 32'd8);
    chk("starve_dma_denied", 32'(seq[8]), 32'b001);
    chk("starve_dma_resume", 32'(seq[9]), 32'b100);
    rq = '0; persist = '0; drive(); step(); step();

    // Lock: 20 cycles of locked DMA against a waiting fetch
    do_reset();
    persist = 3'b100; lock_v = 1'b1; n_dma = 0;
    set_req(2, 1'b1, 32'h300, 32'h7777_0000, 4'hF);
    set_req(1, 1'b0, 32'h304, 32'h0, 4'h0);
    drive();
    for (int c = 0; c < 20; c++) begin
      step();
      seq[c] = a_gnt;
      if (c < 16 && a_gnt == 3'b100) n_dma++;
    end
    chk("lock_dma_grants", 32'(n_dma), 32'd16);
    chk("lock_holdoff_instr", 32'(seq[16]), 32'b010);
    chk("lock_relock_dma", 32'(seq[17]), 32'b100);
    chk("lock_still_dma", 32'(seq[19]), 32'b100);
    rq = '0; persist = '0; lock_v = 1'b0; drive(); step();

    // Back-to-back reads from alternating owners
    set_req(1, 1'b0, 32'h400, 32'h0, 4'h0); drive(); step();
    set_req(0, 1'b0, 32'h404, 32'h0, 4'hF); drive(); step();
    chk("alt_instr_rvalid", 32'(a_rvalid), 32'b010);
    set_req(2, 1'b0, 32'h408, 32'h0, 4'hF); drive(); step();
    chk("alt_data_rvalid", 32'(a_rvalid), 32'b001);
    step();
    chk("alt_dma_rvalid", 32'(a_rvalid), 32'b100);
    step();
    chk("alt_idle_rvalid", 32'(a_rvalid), 32'b000);
`endif

    // Reset right after a granted data read drops its rvalid
    set_req(0, 1'b0, 32'h10, 32'h0, 4'hF); drive(); step();
    rstn = 1'b0; rq = '0; lock_v = 1'b0; drive(); model_reset();
    @(negedge clk);
    chk("midrst_data_rvalid", 32'(bus.data_rvalid), 32'd0);
    @(posedge clk); #1; rstn = 1'b1;
    step();
    chk("midrst_rvalid_after", 32'(a_rvalid), 32'd0);

    // Reset drops an active lock
    lock_v = 1'b1; set_req(2, 1'b0, 32'h20, 32'h0, 4'hF); drive(); step();
    chk("prelock_dma", 32'(a_gnt), 32'b100);
    rstn = 1'b0; rq = '0; drive(); model_reset();
    @(posedge clk); #1; rstn = 1'b1;
    set_req(0, 1'b0, 32'h24, 32'h0, 4'hF); drive(); step();
    chk("postrst_unlocked", 32'(a_gnt), 32'b001);
    lock_v = 1'b0; rq = '0; drive(); step();

`ifdef DTCM_ARB_RR_EN
    do_reset();
    set_req(0, 1'b0, 32'h30, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h34, 32'h0, 4'h0);
    set_req(2, 1'b0, 32'h38, 32'h0, 4'hF);
    drive(); step(); seq[0] = a_gnt; step(); seq[1] = a_gnt; step(); seq[2] = a_gnt;
    chk("rr_first_data", 32'(seq[0]), 32'b001);
    chk("rr_second_instr", 32'(seq[1]), 32'b010);
    chk("rr_third_dma", 32'(seq[2]), 32'b100);
    step();
`endif

    // Randomized traffic against the model
    do_reset();
    verbose = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!rq[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)),
                  ($urandom & 32'hFFFF_8003) | (32'($urandom_range(0, 63)) << 2),
                  $urandom, (i == 0) ? 4'($urandom) : 4'hF);
      end
      if ($urandom_range(0, 23) == 0) lock_v = ~lock_v;
      drive(); step();
    end
    rq = '0; lock_v = 1'b0; drive(); step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dtcm_arbiter.md
Name: dtcm_arbiter

Overview:
- Arbitrates the single-port DTCM SRAM between three requesters: core data port, core instruction-fetch port and DMA.
- Each cycle it grants at most one access, drives the SRAM command, and returns read data to the owning requester one cycle later.
- Sits between the core/DMA interconnect and the DTCM SRAM macro. It replaces ad-hoc OR/priority muxing with explicit grants, starvation protection and a DMA burst lock.

Parameters:
- AW, 32, byte address width of requester ports
- DW, 32, data width
- WORD_AW, 13, SRAM word address width; mem_addr = addr[WORD_AW+1:2]
- STARVE_LIMIT, 8, consecutive denied cycles before a requester is promoted to top priority
- LOCK_MAX, 16, maximum consecutive DMA lock grants before a forced one-cycle release

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- data_req  in  1  core data access request
- data_rd0_wr1  in  1  data command, 0 = read, 1 = write
- data_addr  in  AW  data byte address
- data_wdata  in  DW  data write data
- data_be  in  4  data byte strobes
- data_gnt  out  1  data request accepted this cycle
- data_rdata  out  DW  data read data
- data_rvalid  out  1  data read data valid
- instr_req  in  1  fetch request (read only)
- instr_addr  in  AW  fetch address
- instr_gnt  out  1  fetch accepted this cycle
- instr_rdata  out  DW  fetch data
- instr_rvalid  out  1  fetch data valid
- dma_req  in  1  DMA request
- dma_rd0_wr1  in  1  DMA command
- dma_lock  in  1  DMA requests burst ownership
- dma_addr  in  AW  DMA byte address
- dma_wdata  in  DW  DMA write data (always full word)
- dma_gnt  out  1  DMA accepted this cycle
- dma_rdata  out  DW  DMA read data
- dma_rvalid  out  1  DMA read data valid
- mem_cs  out  1  SRAM chip select
- mem_we  out  1  SRAM write enable
- mem_addr  out  WORD_AW  SRAM word address
- mem_wdata  out  DW  SRAM write data
- mem_be  out  4  SRAM byte enables
- mem_rdata  in  DW  SRAM read data, registered by the SRAM, valid the cycle after mem_cs

Behaviour:
- Grants are combinational from the requests and registered state. At most one *_gnt is high per cycle, and a grant is only ever given to a requester whose req is high.
- A request is held until granted; the requester must keep its address, command and data stable until then.
- Command mux:
  - mem_cs = OR of grants.
  - mem_we = granted command is a write.
  - mem_be = data_be for data, 4'hF for DMA, 4'h0 for fetch.
  - mem_addr and mem_wdata come from the granted requester. When nothing is granted they are 0.
- Base priority (fixed): dma > data > instr.
- Starvation:
  - Each requester has a saturating counter. It increments when the requester has req high and no grant, and clears on grant or when req is low.
  - A counter reaching STARVE_LIMIT marks that requester starved.
  - A starved requester outranks all non-starved ones. Among several starved requesters, base priority applies.
  - Starvation does not break an active DMA lock, but it does win the forced release cycle.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED when dma_gnt and dma_lock are both high.
  - In LOCKED, only DMA may be granted (data_gnt = instr_gnt = 0), and a lock counter counts DMA grants.
  - LOCKED -> UNLOCKED when dma_lock is low. The cycle dma_lock is seen low is arbitrated normally.
  - LOCKED -> UNLOCKED, forced, once LOCK_MAX grants have been given. The next cycle DMA is excluded from arbitration (one holdoff cycle), then arbitration is normal and DMA may relock.
- Read return:
  - A registered owner tag (none/data/instr/dma) is set for a granted read.
  - The next cycle, the owner's rvalid = 1; all other rvalids are 0.
  - All *_rdata = mem_rdata.
  - Writes produce no rvalid.
  - Back-to-back reads from different requesters are allowed, giving one rvalid per cycle to alternating owners.
- Reset values: all rvalids 0, owner tag none, FSM UNLOCKED, all counters 0, holdoff 0. With no requests, all gnt and mem_* outputs are 0.
- Reset mid-operation: an in-flight read loses its rvalid. A lock is dropped.
- Address bits above WORD_AW+1 and bits [1:0] are ignored.

Optional Feature:
- Macro: DTCM_ARB_RR_EN.
- Defined: base priority is round-robin among data, instr and dma. A last-granted pointer (reset: dma) rotates so the requester after the last grant ranks highest. The pointer updates on every grant outside LOCKED. Starvation promotion and lock behave as above.
- Undefined: fixed priority dma > data > instr, and the pointer logic is absent.

Test Plan:
- data read addr 0x0000_0010 only -> data_gnt same cycle, mem_addr=4, mem_we=0; next cycle data_rvalid=1, data_rdata=mem_rdata, other rvalids 0.
- data write addr 0x20 wdata 0xA5A5_0000 be 4'b1100 together with DMA write addr 0x40 -> DMA granted first with mem_be=4'hF; data granted the next cycle with mem_addr=8, mem_be=4'b1100.
- DMA requesting continuously without lock, data requesting continuously, STARVE_LIMIT=8 -> data_gnt high on the 9th data cycle; DMA is denied that cycle and resumes the next.
- dma_lock held, DMA requesting 20 cycles, LOCK_MAX=16, instr requesting -> 16 DMA grants, then instr_gnt in the holdoff cycle, then DMA relocks.
- Alternating grants: instr read, then data read, then DMA read on consecutive cycles -> instr_rvalid, data_rvalid, dma_rvalid each 1 in successive cycles, never two high at once.
- Assert rstn low for one cycle right after a granted data read -> data_rvalid stays 0 and FSM is UNLOCKED after reset; with DTCM_ARB_RR_EN defined, all three requesting after reset -> grant order data, instr, dma.
